// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU in the EX stage.
// Result is {remainder, quotient}; it is held while start_i stays high and is cleared when start_i drops or on annul.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  // state   | meaning
  // IDLE    | waiting for start_i; captures operands
  // DIVZERO | divisor was zero; zero result is loaded next edge
  // BUSY    | one quotient bit per cycle while cnt < 32
  // DONE    | result valid, held until start_i drops
  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [64:0] w;
  logic [5:0]  cnt;
  logic [31:0] mag_b;
  logic        neg_q, neg_r;

  logic [31:0] mag_a_in, mag_b_in;
  logic [64:0] w_shift;
  logic [32:0] diff;
  logic [31:0] quo, rem;
  logic        capture;

  assign mag_a_in = (signed_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
  assign mag_b_in = (signed_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
  assign w_shift  = {w[63:0], 1'b0};
  assign diff     = w_shift[64:32] - {1'b0, mag_b};
  assign quo      = w[31:0];
  assign rem      = w[63:32];
  assign capture  = start_i && !annul_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = (opdata2_i == 32'd0) ? DIVZERO : BUSY;
      DIVZERO: state_nxt = annul_i ? IDLE : DONE;
      BUSY: begin
        if (annul_i)            state_nxt = IDLE;
        else if (cnt == 6'd32)  state_nxt = DONE;
      end
      DONE:    if (annul_i || !start_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w        <= '0;
      cnt      <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (capture && opdata2_i != 32'd0) begin
            w     <= {33'b0, mag_a_in};
            mag_b <= mag_b_in;
            neg_q <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_r <= signed_i & opdata1_i[31];
            cnt   <= '0;
          end
        end
        DIVZERO: begin
          result_o <= '0;
          ready_o  <= !annul_i;
        end
        BUSY: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (cnt == 6'd32) begin
            // Sign correction is applied to magnitudes; 0x80000000 wraps naturally.
            result_o <= {neg_r ? (32'd0 - rem) : rem, neg_q ? (32'd0 - quo) : quo};
            ready_o  <= 1'b1;
          end else begin
            if (!diff[32]) w <= {diff, w_shift[31:1], 1'b1};
            else           w <= w_shift;
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (annul_i || !start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor pops on each ready rise.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start_i, signed_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  logic        prev_ready = 1'b0;

  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: result=%h with no pending request", result_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (result_o !== exp_v) begin
          fails++;
          $display("FAIL result: got %h expected %h", result_o, exp_v);
        end
      end
    end
    prev_ready = ready_o;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the capture edge; counts edges until ready_o is seen.
  task automatic wait_ready(input int lat, input string name);
    int n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
  endtask

  task automatic hold_and_drop(input logic [63:0] exp, input string name);
    repeat (2) tick();
    check({name, "_hold_ready"}, {63'b0, ready_o}, 64'd1);
    check({name, "_hold_result"}, result_o, exp);
    start_i = 1'b0;
    tick();
    check({name, "_drop_ready"}, {63'b0, ready_o}, 64'd0);
    check({name, "_drop_result"}, result_o, 64'd0);
    tick();
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input string name);
    exp_q.push_back(exp);
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    tick();
    // Captured operands must be immune to later changes.
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_i  = 1'($urandom);
    wait_ready(lat, name);
    hold_and_drop(exp, name);
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) tick();
    check("reset_ready", {63'b0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b1;
    tick();

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "u_100_7");
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "s_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, "s_7_m2");
    run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3}, 33, "s_m7_m2");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, "s_ovf");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33, "u_max_1");
    run_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33, "u_5_9");
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33, "u_max_16");
    run_div(1'b1, 32'd1234, 32'd0, 64'd0, 1, "s_divzero");
    run_div(1'b0, 32'd1234, 32'd0, 64'd0, 1, "u_divzero");

    // Annul at step 10: no result may appear.
    signed_i = 1'b0; opdata1_i = 32'd77777; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    repeat (10) tick();
    annul_i = 1'b1;
    tick();
    check("annul_ready", {63'b0, ready_o}, 64'd0);
    check("annul_result", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (3) tick();
    check("annul_idle_ready", {63'b0, ready_o}, 64'd0);
    run_div(1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, "after_annul");

    // start and annul together in IDLE: annul wins, nothing is captured.
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    tick();
    start_i = 1'b0; annul_i = 1'b0;
    repeat (40) tick();
    check("annul_vs_start_ready", {63'b0, ready_o}, 64'd0);

    // Reset at step 20 with start held: divide restarts from a fresh capture.
    exp_q.push_back({32'hFFFFFCEB, 32'hFFFE1DC0});
    signed_i = 1'b1; opdata1_i = 32'hF8A432EB; opdata2_i = 32'd1000; start_i = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b0;
    tick();
    check("midreset_ready", {63'b0, ready_o}, 64'd0);
    check("midreset_result", result_o, 64'd0);
    rst = 1'b1;
    tick();
    wait_ready(33, "restart");
    hold_and_drop({32'hFFFFFCEB, 32'hFFFE1DC0}, "restart");

    repeat (5) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX presents operands and holds `start_i` high, stalling the pipeline while `ready_o` is low. It accepts the 64-bit result as the HI/LO write value (HI = remainder, LO = quotient) on the cycle `ready_o` is high. The unit runs a radix-2 restoring algorithm, one quotient bit per cycle, with optional signed correction and annulment on pipeline flush.

## Interface
- No parameters; width is fixed at 32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low; `rst == 0` at an edge resets the block.
- `start_i`  in  1  divide request; held high by EX until it consumes the result.
- `signed_i`  in  1  1 selects DIV (two's complement), 0 selects DIVU; sampled at capture.
- `opdata1_i`  in  32  dividend; sampled at capture.
- `opdata2_i`  in  32  divisor; sampled at capture.
- `annul_i`  in  1  flush or exception; aborts any operation in flight.
- `result_o`  out  64  {remainder, quotient}; [63:32] goes to HI, [31:0] goes to LO.
- `ready_o`  out  1  result valid.

## Operation
- States: IDLE, DIVZERO, BUSY, DONE. Registers: `W[64:0]`, `cnt[5:0]`, `mag_b[31:0]`, `neg_q`, `neg_r`.
- Transitions from IDLE:
  - `start_i & ~annul_i` with `opdata2_i == 0`: go to DIVZERO.
  - `start_i & ~annul_i` otherwise: capture and go to BUSY, with `cnt = 0`.
  - Any other input: stay in IDLE.
- Capture actions:
  - `|a|`: `opdata1_i` if unsigned or non-negative, otherwise `-opdata1_i`, taken mod 2^32. `|b|` is formed the same way from `opdata2_i`.
  - Load `W = {33'b0, |a|}` and `mag_b = |b|`.
  - Set `neg_q = signed_i & (a[31] ^ b[31])` and `neg_r = signed_i & a[31]`.
- BUSY step, for `cnt < 32`:
  - `W' = W << 1` and `d = W'[64:32] - {1'b0, mag_b}` (33-bit).
  - If `d` is non-negative: `W[64:32] = d` and `W[0] = 1`. Otherwise `W = W'`.
  - `cnt` increments by 1.
- BUSY at `cnt == 32`:
  - Set `q = W[31:0]` and `r = W[63:32]`.
  - Load `result_o = {neg_r ? -r : r, neg_q ? -q : q}`, with both negations mod 2^32.
  - Set `ready_o = 1` and go to DONE.
- DIVZERO: at the next edge load `result_o = 64'b0`, set `ready_o = 1` and go to DONE. Division by zero returns zero; no exception is raised.
- DONE:
  - While `start_i == 1`: hold `result_o` and `ready_o = 1`.
  - When `start_i == 0`: go to IDLE, clear `ready_o` to 0 and `result_o` to 0.
- Annulment: `annul_i == 1` in DIVZERO, BUSY or DONE sends the block to IDLE at the next edge with `ready_o = 0` and `result_o = 0`. In IDLE, `annul_i` blocks capture.
- Signed overflow: 0x80000000 / 0xFFFFFFFF returns quotient 0x80000000 and remainder 0, with no trap.
- Operand changes after capture are ignored.

## Timing
- Reset: at any edge with `rst == 0`, the block goes to IDLE with `ready_o = 0`, `result_o = 0`, `cnt = 0` and `W = 0`. Reset overrides `start_i` and `annul_i` and aborts any operation in flight.
- Normal divide, with capture at edge E0:
  - Edges E1 to E32 perform the 32 steps.
  - E33 loads the result.
  - `ready_o` is high from E33 to the first edge that samples `start_i == 0`.
- Divide by zero: capture at E0 enters DIVZERO; `ready_o` is high after E1.
- Back-to-back divides: at least one IDLE cycle separates them, since EX must drop `start_i` for at least one cycle.
- `ready_o` and `result_o` are registered; there is no combinational path from any input.
- Annul has one-edge latency.
- If `start_i` and `annul_i` rise together in IDLE, annul wins: no capture.

## Test plan
- Unsigned, 100 / 7, `signed_i = 0`: `ready_o` rises exactly 33 edges after capture with `result_o = {32'd2, 32'd14}`. Dropping `start_i` then gives `ready_o = 0` and `result_o = 0` one edge later.
- Signed sign combinations:
  - -7 / 2 gives {0xFFFFFFFF, 0xFFFFFFFD}.
  - 7 / -2 gives {1, 0xFFFFFFFD}.
  - -7 / -2 gives {0xFFFFFFFF, 3}.
- Corners:
  - Signed 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
  - Unsigned 5 / 9 gives {5, 0}.
- Divide by zero, 1234 / 0 with both signed and unsigned: `ready_o` is high after E1 with `result_o = 0`. The block reaches IDLE once `start_i` drops.
- Annul: raise `annul_i` at step 10 of a divide; the block is in IDLE next edge and `ready_o` stays 0. A new divide started right after completes correctly in 33 edges.
- Reset mid-operation: pull `rst` low at step 20 for one edge; all outputs are 0 and the state is IDLE. With `start_i` held high, the divide restarts and completes 33 edges after the new capture.
